ps_irq_ctrl: RTL and testbench
==============================

PS_IRQ_CTRL -- requirements
Module: ps_irq_ctrl

Interface
REQ-001 SHALL have parameter NIRQ, default 4, number of interrupt lines (1..8).
REQ-002 SHALL have parameter VEC_BASE, default 16'h0040, PM address of vector 0.
REQ-003 SHALL have parameter VEC_SHIFT, default 2, log2 of vector spacing in PM words.
REQ-004 SHALL have port clk, input, 1, clock (rising edge).
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port irq_req, input, NIRQ, external requests; each line is edge-sensitive on its rising edge.
REQ-007 SHALL have port ps_irq_ack, input, 1, sequencer has pushed the PC and redirected fetch to irq_ps_vec.
REQ-008 SHALL have port ps_irq_rti, input, 1, sequencer executed a return-from-interrupt.
REQ-009 SHALL have port ps_irq_wrt_en, input, 1, register write strobe.
REQ-010 SHALL have port ps_irq_wrt_sel, input, 1, write target: 0 = IMASK load, 1 = IRPTL clear-by-mask.
REQ-011 SHALL have port ps_irq_wdt, input, NIRQ, write data.
REQ-012 SHALL have port irq_ps_vld, output, 1, vector request to the sequencer.
REQ-013 SHALL have port irq_ps_vec, output, 16, vector address.
REQ-014 SHALL have port irq_ps_wake, output, 1, an unmasked interrupt is latched (idle exit).
REQ-015 SHALL have port irq_imask, output, NIRQ, current mask register.
REQ-016 SHALL have port irq_irptl, output, NIRQ, latched pending register.
REQ-017 SHALL have port irq_imaskp, output, NIRQ, in-service bitset.

Function
REQ-018 SHALL register irq_req into irq_req_q each cycle; irptl[i] SHALL set in the cycle after irq_req[i] & !irq_req_q[i].
REQ-019 SHALL compute eligible = irptl & imask & ~blk, with priority lowest index first.
REQ-020 SHALL implement a three-state FSM: IDLE, REQ, SVC.
REQ-021 SHALL, in IDLE with eligible != 0, latch idx = highest-priority eligible bit, go to REQ, and assert irq_ps_vld with irq_ps_vec = VEC_BASE + (idx << VEC_SHIFT), truncated to 16 bits; rising edge at cycle n gives vld at cycle n+2.
REQ-022 SHALL, in REQ, hold irq_ps_vld and irq_ps_vec stable until ps_irq_ack, even if IMASK or IRPTL writes remove the request.
REQ-023 SHALL, on ack in REQ, clear irptl[idx], set imaskp[idx], deassert vld next cycle, and enter SVC.
REQ-024 SHALL, on ps_irq_rti in SVC, clear the highest-priority set bit of imaskp; SHALL enter IDLE when imaskp becomes 0, else stay in SVC.
REQ-025 SHALL ignore ps_irq_rti in IDLE and REQ.
REQ-026 SHALL let a set event win when an edge and an ack-clear or write-clear hit the same irptl bit in one cycle.
REQ-027 SHALL apply IMASK writes (imask <= wdt) and IRPTL clears (irptl &= ~wdt) at the clock edge; the new values take effect for arbitration in the next cycle.
REQ-028 SHALL register irq_ps_wake = |(irptl & imask).

Reset
REQ-029 SHALL, while rst = 0, force state IDLE, irptl = 0, imask = all-ones, imaskp = 0, irq_req_q = 0, irq_ps_vld = 0, irq_ps_vec = 0, irq_ps_wake = 0; a reset mid-REQ drops the request without an ack.

Configuration
REQ-030 SHALL support macro PS_IRQ_NEST_EN.
REQ-031 SHALL, with PS_IRQ_NEST_EN defined, set blk = mask of bits at or below the priority of the highest-priority imaskp bit, and leave SVC for REQ when eligible != 0.
REQ-032 SHALL, without PS_IRQ_NEST_EN, set blk = all-ones while in SVC, so no request is issued until imaskp = 0.

Structure
REQ-033 SHALL place the FSM state enum and the IRPTL/IMASK write-select constants in shared package ps_pkg.
REQ-034 SHALL instantiate one sub-module, ps_irq_prio_enc (NIRQ-bit priority encoder giving index and valid), used for both arbitration and the RTI bit clear.

Verification
REQ-035 Rise on irq_req[2] at cycle 0 with imask = 4'hF -> vld at cycle 2, vec = 16'h0048; ack at cycle 4 -> irptl[2] = 0, imaskp = 4'b0100.
REQ-036 Rises on irq_req[3] and irq_req[1] in the same cycle -> vec = 16'h0044 first; after ack and rti -> vec = 16'h004C.
REQ-037 Write IMASK = 4'b1110, then rise on irq_req[0] -> irptl = 4'b0001, no vld, wake = 0; write IMASK = 4'hF -> vld with vec = 16'h0040.
REQ-038 In SVC for line 2, rise on irq_req[0] -> with PS_IRQ_NEST_EN: vld, vec = 16'h0040, imaskp = 4'b0101 after ack; without it: no vld until rti.
REQ-039 Edge and IRPTL-clear write on the same bit in one cycle -> bit stays set; rst low while in REQ -> vld = 0, imask = 4'hF next cycle.

Source files
------------

// File: rtl/ps_pkg.sv
// Shared definitions for the program-sequencer interrupt block:
// FSM state encoding and write-select codes for the IMASK/IRPTL port.
package ps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } irq_state_t;

    localparam logic WSEL_IMASK = 1'b0;
    localparam logic WSEL_IRPTL = 1'b1;

endpackage

// File: rtl/ps_irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins. vld is set when any bit is set.
module ps_irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] bits,
    output logic [2:0]   idx,
    output logic         vld
);

    always_comb begin
        idx = '0;
        vld = |bits;
        // Scan downward so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/ps_irq_ctrl.sv
// Edge-latched interrupt controller feeding vector requests to the program sequencer.
// Optional nesting of higher-priority interrupts is enabled with macro PS_IRQ_NEST_EN.
module ps_irq_ctrl
    import ps_pkg::*;
#(
    parameter int          NIRQ      = 4,
    parameter logic [15:0] VEC_BASE  = 16'h0040,
    parameter int          VEC_SHIFT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_req,
    input  logic            ps_irq_ack,
    input  logic            ps_irq_rti,
    input  logic            ps_irq_wrt_en,
    input  logic            ps_irq_wrt_sel,
    input  logic [NIRQ-1:0] ps_irq_wdt,
    output logic            irq_ps_vld,
    output logic [15:0]     irq_ps_vec,
    output logic            irq_ps_wake,
    output logic [NIRQ-1:0] irq_imask,
    output logic [NIRQ-1:0] irq_irptl,
    output logic [NIRQ-1:0] irq_imaskp
);

    localparam logic [NIRQ-1:0] ONE = 1;

    irq_state_t      state;
    logic [2:0]      idx;
    logic [NIRQ-1:0] irq_req_q;
    logic [NIRQ-1:0] irptl;
    logic [NIRQ-1:0] imask;
    logic [NIRQ-1:0] imaskp;
    logic [NIRQ-1:0] irptl_n;
    logic [NIRQ-1:0] imaskp_n;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] blk;
    logic [NIRQ-1:0] eligible;
    logic [2:0]      arb_idx;
    logic            arb_vld;
    logic [2:0]      svc_idx;
    logic            svc_vld;
    logic [15:0]     arb_vec;

    assign rise     = irq_req & ~irq_req_q;
    assign eligible = irptl & imask & ~blk;
    assign arb_vec  = VEC_BASE + (16'(arb_idx) << VEC_SHIFT);

    ps_irq_prio_enc #(.N(NIRQ)) u_arb_enc (
        .bits (eligible),
        .idx  (arb_idx),
        .vld  (arb_vld)
    );

    ps_irq_prio_enc #(.N(NIRQ)) u_svc_enc (
        .bits (imaskp),
        .idx  (svc_idx),
        .vld  (svc_vld)
    );

    always_comb begin
        blk = '0;
`ifdef PS_IRQ_NEST_EN
        // Block the active service level and everything of lower priority.
        for (int i = 0; i < NIRQ; i++) begin
            blk[i] = svc_vld && (3'(i) >= svc_idx);
        end
`else
        if (state == ST_SVC) blk = '1;
`endif
    end

    // Clears are applied first so a same-cycle rising edge keeps the bit set.
    always_comb begin
        irptl_n = irptl;
        if (ps_irq_wrt_en && ps_irq_wrt_sel == WSEL_IRPTL) irptl_n = irptl_n & ~ps_irq_wdt;
        if (state == ST_REQ && ps_irq_ack) irptl_n = irptl_n & ~(ONE << idx);
        irptl_n = irptl_n | rise;
    end

    always_comb begin
        imaskp_n = imaskp;
        if (state == ST_REQ && ps_irq_ack) imaskp_n = imaskp | (ONE << idx);
        else if (state == ST_SVC && ps_irq_rti && svc_vld) imaskp_n = imaskp & ~(ONE << svc_idx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_req_q   <= '0;
            irptl       <= '0;
            imask       <= '1;
            imaskp      <= '0;
            irq_ps_wake <= 1'b0;
        end else begin
            irq_req_q   <= irq_req;
            irptl       <= irptl_n;
            imaskp      <= imaskp_n;
            irq_ps_wake <= |(irptl & imask);
            if (ps_irq_wrt_en && ps_irq_wrt_sel == WSEL_IMASK) imask <= ps_irq_wdt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            irq_ps_vld <= 1'b0;
            irq_ps_vec <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        state      <= ST_REQ;
                        idx        <= arb_idx;
                        irq_ps_vld <= 1'b1;
                        irq_ps_vec <= arb_vec;
                    end
                end
                ST_REQ: begin
                    // The request is held until acked, regardless of mask changes.
                    if (ps_irq_ack) begin
                        state      <= ST_SVC;
                        irq_ps_vld <= 1'b0;
                    end
                end
                ST_SVC: begin
                    if (ps_irq_rti) begin
                        if (imaskp_n == '0) state <= ST_IDLE;
                    end
`ifdef PS_IRQ_NEST_EN
                    else if (arb_vld) begin
                        state      <= ST_REQ;
                        idx        <= arb_idx;
                        irq_ps_vld <= 1'b1;
                        irq_ps_vec <= arb_vec;
                    end
`endif
                end
                default: begin
                    state      <= ST_IDLE;
                    irq_ps_vld <= 1'b0;
                end
            endcase
        end
    end

    assign irq_imask  = imask;
    assign irq_irptl  = irptl;
    assign irq_imaskp = imaskp;

endmodule

// File: tb/tb_ps_irq_ctrl.sv
// Directed bench for ps_irq_ctrl with default parameters; nesting expectations follow PS_IRQ_NEST_EN.
module tb_ps_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_req;
    logic        ps_irq_ack;
    logic        ps_irq_rti;
    logic        ps_irq_wrt_en;
    logic        ps_irq_wrt_sel;
    logic [3:0]  ps_irq_wdt;
    logic        irq_ps_vld;
    logic [15:0] irq_ps_vec;
    logic        irq_ps_wake;
    logic [3:0]  irq_imask;
    logic [3:0]  irq_irptl;
    logic [3:0]  irq_imaskp;

    int checks = 0;
    int errors = 0;

    ps_irq_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .irq_req        (irq_req),
        .ps_irq_ack     (ps_irq_ack),
        .ps_irq_rti     (ps_irq_rti),
        .ps_irq_wrt_en  (ps_irq_wrt_en),
        .ps_irq_wrt_sel (ps_irq_wrt_sel),
        .ps_irq_wdt     (ps_irq_wdt),
        .irq_ps_vld     (irq_ps_vld),
        .irq_ps_vec     (irq_ps_vec),
        .irq_ps_wake    (irq_ps_wake),
        .irq_imask      (irq_imask),
        .irq_irptl      (irq_irptl),
        .irq_imaskp     (irq_imaskp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        ps_irq_ack = 1'b1; tick(); ps_irq_ack = 1'b0;
    endtask

    task automatic rti_pulse();
        ps_irq_rti = 1'b1; tick(); ps_irq_rti = 1'b0;
    endtask

    task automatic write_reg(input logic sel, input logic [3:0] data);
        ps_irq_wrt_en = 1'b1; ps_irq_wrt_sel = sel; ps_irq_wdt = data;
        tick();
        ps_irq_wrt_en = 1'b0; ps_irq_wdt = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0; irq_req = 4'h0; ps_irq_ack = 1'b0; ps_irq_rti = 1'b0;
        ps_irq_wrt_en = 1'b0; ps_irq_wrt_sel = 1'b0; ps_irq_wdt = 4'h0;
        tick(2);
        checks++; if (irq_ps_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", irq_ps_vld); end
        checks++; if (irq_ps_vec !== 16'h0000) begin errors++; $display("FAIL reset_vec got %h exp 0000", irq_ps_vec); end
        checks++; if (irq_imask !== 4'hF) begin errors++; $display("FAIL reset_imask got %h exp f", irq_imask); end
        checks++; if (irq_irptl !== 4'h0 || irq_imaskp !== 4'h0 || irq_ps_wake !== 1'b0) begin
            errors++; $display("FAIL reset_regs got irptl %h imaskp %h wake %b exp 0 0 0", irq_irptl, irq_imaskp, irq_ps_wake);
        end
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        irq_req = 4'b0100;
        tick();
        checks++; if (irq_ps_vld !== 1'b0 || irq_irptl !== 4'b0100) begin
            errors++; $display("FAIL single_c1 got vld %b irptl %b exp 0 0100", irq_ps_vld, irq_irptl);
        end
        tick();
        checks++; if (irq_ps_vld !== 1'b1 || irq_ps_vec !== 16'h0048) begin
            errors++; $display("FAIL single_vld got vld %b vec %h exp 1 0048", irq_ps_vld, irq_ps_vec);
        end
        checks++; if (irq_ps_wake !== 1'b1) begin errors++; $display("FAIL single_wake got %b exp 1", irq_ps_wake); end
        rti_pulse();
        checks++; if (irq_ps_vld !== 1'b1 || irq_ps_vec !== 16'h0048 || irq_imaskp !== 4'b0000) begin
            errors++; $display("FAIL single_rti_in_req got vld %b vec %h imaskp %b exp 1 0048 0000", irq_ps_vld, irq_ps_vec, irq_imaskp);
        end
        ack_pulse();
        checks++; if (irq_ps_vld !== 1'b0 || irq_irptl !== 4'b0000 || irq_imaskp !== 4'b0100) begin
            errors++; $display("FAIL single_ack got vld %b irptl %b imaskp %b exp 0 0000 0100", irq_ps_vld, irq_irptl, irq_imaskp);
        end
        irq_req = 4'b0000;
        rti_pulse();
        checks++; if (irq_imaskp !== 4'b0000 || irq_ps_vld !== 1'b0) begin
            errors++; $display("FAIL single_rti got imaskp %b vld %b exp 0000 0", irq_imaskp, irq_ps_vld);
        end
        tick();
    endtask

    task automatic test_priority();
        irq_req = 4'b1010;
        tick(2);
        checks++; if (irq_ps_vld !== 1'b1 || irq_ps_vec !== 16'h0044) begin
            errors++; $display("FAIL prio_first got vld %b vec %h exp 1 0044", irq_ps_vld, irq_ps_vec);
        end
        ack_pulse();
        checks++; if (irq_irptl !== 4'b1000 || irq_imaskp !== 4'b0010) begin
            errors++; $display("FAIL prio_ack got irptl %b imaskp %b exp 1000 0010", irq_irptl, irq_imaskp);
        end
        tick();
        checks++; if (irq_ps_vld !== 1'b0) begin errors++; $display("FAIL prio_blocked got vld %b exp 0", irq_ps_vld); end
        irq_req = 4'b0000;
        rti_pulse();
        tick();
        checks++; if (irq_ps_vld !== 1'b1 || irq_ps_vec !== 16'h004C) begin
            errors++; $display("FAIL prio_second got vld %b vec %h exp 1 004c", irq_ps_vld, irq_ps_vec);
        end
        ack_pulse();
        rti_pulse();
        tick();
    endtask

    task automatic test_mask();
        write_reg(1'b0, 4'b1110);
        checks++; if (irq_imask !== 4'b1110) begin errors++; $display("FAIL mask_write got %b exp 1110", irq_imask); end
        irq_req = 4'b0001;
        tick(3);
        checks++; if (irq_irptl !== 4'b0001 || irq_ps_vld !== 1'b0 || irq_ps_wake !== 1'b0) begin
            errors++; $display("FAIL mask_blocked got irptl %b vld %b wake %b exp 0001 0 0", irq_irptl, irq_ps_vld, irq_ps_wake);
        end
        write_reg(1'b0, 4'hF);
        tick();
        checks++; if (irq_ps_vld !== 1'b1 || irq_ps_vec !== 16'h0040) begin
            errors++; $display("FAIL mask_unblocked got vld %b vec %h exp 1 0040", irq_ps_vld, irq_ps_vec);
        end
        irq_req = 4'b0000;
        ack_pulse();
        rti_pulse();
        tick();
    endtask

    task automatic test_nest();
        irq_req = 4'b0100;
        tick(2);
        ack_pulse();
        checks++; if (irq_imaskp !== 4'b0100) begin errors++; $display("FAIL nest_svc got imaskp %b exp 0100", irq_imaskp); end
        irq_req = 4'b0101;
        tick(2);
`ifdef PS_IRQ_NEST_EN
        checks++; if (irq_ps_vld !== 1'b1 || irq_ps_vec !== 16'h0040) begin
            errors++; $display("FAIL nest_vld got vld %b vec %h exp 1 0040", irq_ps_vld, irq_ps_vec);
        end
        ack_pulse();
        checks++; if (irq_imaskp !== 4'b0101 || irq_irptl !== 4'b0000) begin
            errors++; $display("FAIL nest_ack got imaskp %b irptl %b exp 0101 0000", irq_imaskp, irq_irptl);
        end
        rti_pulse();
        checks++; if (irq_imaskp !== 4'b0100) begin errors++; $display("FAIL nest_rti1 got imaskp %b exp 0100", irq_imaskp); end
        rti_pulse();
`else
        tick(2);
        checks++; if (irq_ps_vld !== 1'b0 || irq_irptl !== 4'b0001) begin
            errors++; $display("FAIL nonest_wait got vld %b irptl %b exp 0 0001", irq_ps_vld, irq_irptl);
        end
        rti_pulse();
        checks++; if (irq_imaskp !== 4'b0000 || irq_ps_vld !== 1'b0) begin
            errors++; $display("FAIL nonest_rti got imaskp %b vld %b exp 0000 0", irq_imaskp, irq_ps_vld);
        end
        tick();
        checks++; if (irq_ps_vld !== 1'b1 || irq_ps_vec !== 16'h0040) begin
            errors++; $display("FAIL nonest_vld got vld %b vec %h exp 1 0040", irq_ps_vld, irq_ps_vec);
        end
        ack_pulse();
        rti_pulse();
`endif
        irq_req = 4'b0000;
        checks++; if (irq_imaskp !== 4'b0000) begin errors++; $display("FAIL nest_done got imaskp %b exp 0000", irq_imaskp); end
        tick();
    endtask

    task automatic test_hold();
        irq_req = 4'b0010;
        tick(2);
        ps_irq_wrt_en = 1'b1; ps_irq_wrt_sel = 1'b1; ps_irq_wdt = 4'b0010;
        tick();
        ps_irq_wrt_sel = 1'b0; ps_irq_wdt = 4'b0000;
        tick();
        ps_irq_wrt_en = 1'b0;
        checks++; if (irq_irptl !== 4'b0000 || irq_imask !== 4'b0000) begin
            errors++; $display("FAIL hold_regs got irptl %b imask %b exp 0000 0000", irq_irptl, irq_imask);
        end
        checks++; if (irq_ps_vld !== 1'b1 || irq_ps_vec !== 16'h0044) begin
            errors++; $display("FAIL hold_req got vld %b vec %h exp 1 0044", irq_ps_vld, irq_ps_vec);
        end
        ack_pulse();
        checks++; if (irq_imaskp !== 4'b0010 || irq_ps_vld !== 1'b0) begin
            errors++; $display("FAIL hold_ack got imaskp %b vld %b exp 0010 0", irq_imaskp, irq_ps_vld);
        end
        irq_req = 4'b0000;
        rti_pulse();
        tick();
    endtask

    task automatic test_collision();
        irq_req = 4'b1000;
        ps_irq_wrt_en = 1'b1; ps_irq_wrt_sel = 1'b1; ps_irq_wdt = 4'b1000;
        tick();
        ps_irq_wrt_en = 1'b0; ps_irq_wdt = 4'b0000;
        checks++; if (irq_irptl !== 4'b1000) begin errors++; $display("FAIL collide_set got irptl %b exp 1000", irq_irptl); end
        write_reg(1'b1, 4'b1000);
        checks++; if (irq_irptl !== 4'b0000) begin errors++; $display("FAIL collide_clear got irptl %b exp 0000", irq_irptl); end
        irq_req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_req();
        write_reg(1'b0, 4'b0010);
        irq_req = 4'b0010;
        tick(2);
        checks++; if (irq_ps_vld !== 1'b1 || irq_ps_vec !== 16'h0044) begin
            errors++; $display("FAIL rstreq_pre got vld %b vec %h exp 1 0044", irq_ps_vld, irq_ps_vec);
        end
        rst = 1'b0; irq_req = 4'b0000;
        #1;
        checks++; if (irq_ps_vld !== 1'b0 || irq_imask !== 4'hF || irq_irptl !== 4'h0) begin
            errors++; $display("FAIL rstreq_async got vld %b imask %h irptl %h exp 0 f 0", irq_ps_vld, irq_imask, irq_irptl);
        end
        tick();
        rst = 1'b1;
        tick(3);
        checks++; if (irq_ps_vld !== 1'b0 || irq_imaskp !== 4'h0 || irq_imask !== 4'hF) begin
            errors++; $display("FAIL rstreq_after got vld %b imaskp %h imask %h exp 0 0 f", irq_ps_vld, irq_imaskp, irq_imask);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_nest();
        test_hold();
        test_collision();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
